// File: rtl/gray_ptr_sync_decoder.sv
// Gray-coded pointer receiver: synchronizes a foreign-domain Gray value into clk,
// decodes it to binary and classifies each sample-to-sample move as +1, -1 or illegal.
module gray_ptr_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CW      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  gray_in,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  bin_out,
  output logic              bin_valid,
  output logic              inc_pulse,
  output logic              dec_pulse,
  output logic              step_err,
  output logic [ERR_CW-1:0] err_cnt
);

  localparam int WCW = $clog2(SYNC_STAGES);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    LOCK   = 2'd1,
    TRACK  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WCW-1:0]     warm_cnt_q, warm_cnt_d;
  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   g_prev_q, g_prev_d;
  logic [WIDTH-1:0]   bin_out_q, bin_out_d;
  logic               bin_valid_q, bin_valid_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               step_err_q, step_err_d;
  logic [ERR_CW-1:0]  err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]   g_s;
  logic [WIDTH-1:0]   bin;
  logic [WIDTH-1:0]   g_diff;
  logic               one_bit_move;

  assign g_s = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(g_s >> i);
    end
  end

  assign g_diff       = g_s ^ g_prev_q;
  assign one_bit_move = (g_diff != '0) && ((g_diff & (g_diff - WIDTH'(1))) == '0);

  // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    g_prev_d    = g_prev_q;
    bin_out_d   = bin_out_q;
    bin_valid_d = bin_valid_q;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    step_err_d  = 1'b0;

    unique case (state_q)
      WARMUP: begin
        if (warm_cnt_q == WCW'(SYNC_STAGES - 1)) begin
          state_d = LOCK;
        end else begin
          warm_cnt_d = warm_cnt_q + WCW'(1);
        end
      end
      LOCK: begin
        bin_out_d   = bin;
        g_prev_d    = g_s;
        bin_valid_d = 1'b1;
        state_d     = TRACK;
      end
      TRACK: begin
        bin_out_d = bin;
        g_prev_d  = g_s;
        if (one_bit_move) begin
          if (bin == bin_out_q + WIDTH'(1)) inc_d = 1'b1;
          else                              dec_d = 1'b1;
        end else if (g_diff != '0) begin
          step_err_d = 1'b1;
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  // A clear coinciding with a new error leaves exactly that one error counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = ERR_CW'(step_err_d);
    end else if (step_err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WARMUP;
      warm_cnt_q  <= '0;
      g_prev_q    <= '0;
      bin_out_q   <= '0;
      bin_valid_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      step_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      g_prev_q    <= g_prev_d;
      bin_out_q   <= bin_out_d;
      bin_valid_q <= bin_valid_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      step_err_q  <= step_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // NOTE: the synchronizer array is a handful of flops, so it is reset like any register, not treated as RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign bin_out   = bin_out_q;
  assign bin_valid = bin_valid_q;
  assign inc_pulse = inc_q;
  assign dec_pulse = dec_q;
  assign step_err  = step_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_ptr_sync_decoder.sv
// Scoreboard bench for gray_ptr_sync_decoder: a cycle model pushes expected outputs at each
// rising edge, and they are popped and compared against the DUT on the following falling edge.
module tb_gray_ptr_sync_decoder;
  localparam int W = 4;
  localparam int S = 2;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] gray_in;
  logic         err_clr;
  logic [W-1:0] bin_out;
  logic         bin_valid, inc_pulse, dec_pulse, step_err;
  logic [E-1:0] err_cnt;

  gray_ptr_sync_decoder #(.WIDTH(W), .SYNC_STAGES(S), .ERR_CW(E)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] bin;
    logic         valid, inc, dec, err;
    logic [E-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   inc_total = 0, dec_total = 0, err_total = 0;
  int   inc_snap, dec_snap, err_snap;

  logic [W-1:0] m_s1, m_s2, m_gprev, m_bin;
  logic         m_valid;
  logic [E-1:0] m_cnt;
  int           m_edges;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b = g;
    for (int s = 1; s < W; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input int v);
    logic [W-1:0] b = W'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_gprev = '0; m_bin = '0;
    m_valid = 1'b0; m_cnt = '0; m_edges = 0;
  endtask

  // Reference behaviour for one rising edge; returns the outputs expected just after it.
  task automatic model_edge(output exp_t e);
    logic [W-1:0] gs, nbin;
    logic         inc, dec, err;
    gs = m_s2; m_s2 = m_s1; m_s1 = gray_in;
    m_edges++;
    inc = 1'b0; dec = 1'b0; err = 1'b0;
    if (m_edges == S + 1) begin
      m_bin = g2b(gs); m_gprev = gs; m_valid = 1'b1;
    end else if (m_edges > S + 1) begin
      nbin = g2b(gs);
      if ($countones(gs ^ m_gprev) == 1) begin
        if (nbin == W'(m_bin + 1)) inc = 1'b1;
        else                       dec = 1'b1;
      end else if ($countones(gs ^ m_gprev) > 1) begin
        err = 1'b1;
      end
      m_bin = nbin; m_gprev = gs;
    end
    if (err_clr)                  m_cnt = err ? E'(1) : E'(0);
    else if (err && m_cnt != '1)  m_cnt = m_cnt + E'(1);
    e = '{bin: m_bin, valid: m_valid, inc: inc, dec: dec, err: err, cnt: m_cnt};
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
      e = '0;
    end else begin
      model_edge(e);
    end
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check("bin_out",   32'(bin_out),   32'(e.bin));
    check("bin_valid", 32'(bin_valid), 32'(e.valid));
    check("inc_pulse", 32'(inc_pulse), 32'(e.inc));
    check("dec_pulse", 32'(dec_pulse), 32'(e.dec));
    check("step_err",  32'(step_err),  32'(e.err));
    check("err_cnt",   32'(err_cnt),   32'(e.cnt));
    inc_total += int'(inc_pulse);
    dec_total += int'(dec_pulse);
    err_total += int'(step_err);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic snap();
    inc_snap = inc_total; dec_snap = dec_total; err_snap = err_total;
  endtask

  initial begin
    rst_n = 1'b0; gray_in = 4'b0110; err_clr = 1'b0;
    model_reset();
    ticks(2);

    // Reset release with a held value: LOCK on the third edge.
    #2 rst_n = 1'b1;
    ticks(2);
    check("t1_valid_warmup", 32'(bin_valid), 32'd0);
    tick();
    check("t1_valid_lock", 32'(bin_valid), 32'd1);
    check("t1_bin_lock", 32'(bin_out), 32'd4);
    ticks(2);

    // Count up through every code, then wrap max -> 0.
    gray_in = 4'b0000;
    ticks(4);
    snap();
    for (int v = 1; v < 16; v++) begin
      gray_in = b2g(v);
      ticks(4);
      check("t2_bin_step", 32'(bin_out), 32'(v));
    end
    gray_in = 4'b0000;
    ticks(4);
    check("t2_bin_wrap", 32'(bin_out), 32'd0);
    check("t2_inc_count", 32'(inc_total - inc_snap), 32'd16);
    check("t2_no_err", 32'(err_total - err_snap), 32'd0);

    // Count down one step, and 0 -> max as a decrement.
    gray_in = b2g(6);
    ticks(4);
    snap();
    gray_in = b2g(5);
    ticks(4);
    check("t3_bin_dec", 32'(bin_out), 32'd5);
    check("t3_dec_count", 32'(dec_total - dec_snap), 32'd1);
    gray_in = 4'b0000;
    ticks(4);
    snap();
    gray_in = 4'b1000;
    ticks(4);
    check("t3_bin_max", 32'(bin_out), 32'd15);
    check("t3_dec_wrap", 32'(dec_total - dec_snap), 32'd1);
    check("t3_no_inc", 32'(inc_total - inc_snap), 32'd0);

    // Illegal jumps, saturation, clear, and clear coinciding with an error.
    gray_in = 4'b0000;
    ticks(4);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    check("t4_cleared", 32'(err_cnt), 32'd0);
    gray_in = 4'b0011;
    ticks(3);
    check("t4_step_err", 32'(step_err), 32'd1);
    check("t4_bin", 32'(bin_out), 32'd2);
    check("t4_cnt1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin
      gray_in = gray_in ^ 4'b0011;
      tick();
    end
    ticks(4);
    check("t4_saturate", 32'(err_cnt), 32'd255);
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    check("t4_clear", 32'(err_cnt), 32'd0);
    gray_in = gray_in ^ 4'b0011;
    ticks(2);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_clr_and_err", 32'(err_cnt), 32'd1);
    check("t4_clr_err_strobe", 32'(step_err), 32'd1);
    ticks(2);

    // Asynchronous reset mid-TRACK, then a clean relock.
    gray_in = b2g(9);
    ticks(4);
    check("t5_bin9", 32'(bin_out), 32'd9);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_async_bin",   32'(bin_out),   32'd0);
    check("t5_async_valid", 32'(bin_valid), 32'd0);
    check("t5_async_inc",   32'(inc_pulse), 32'd0);
    check("t5_async_dec",   32'(dec_pulse), 32'd0);
    check("t5_async_err",   32'(step_err),  32'd0);
    check("t5_async_cnt",   32'(err_cnt),   32'd0);
    ticks(2);
    #2 rst_n = 1'b1;
    snap();
    ticks(2);
    check("t5_valid_warmup", 32'(bin_valid), 32'd0);
    tick();
    check("t5_valid_lock", 32'(bin_valid), 32'd1);
    check("t5_bin_relock", 32'(bin_out), 32'd9);
    ticks(2);
    check("t5_no_strobe", 32'((inc_total - inc_snap) + (dec_total - dec_snap) + (err_total - err_snap)), 32'd0);

    // One legal step every cycle.
    snap();
    for (int i = 0; i < 20; i++) begin
      gray_in = b2g(10 + i);
      tick();
    end
    ticks(4);
    check("t6_inc_count", 32'(inc_total - inc_snap), 32'd20);
    check("t6_no_err", 32'(err_total - err_snap), 32'd0);
    check("t6_bin_final", 32'(bin_out), 32'(29 % 16));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
